// File: rtl/except_ctrl_pkg.sv
// Shared constants for the exception controller: exception codes, flag bit
// positions, CP0 Status/Cause field positions and the bad-address source select.
package except_ctrl_pkg;

    localparam int FLAG_W       = 9;
    localparam int FLAG_ADEL_IF = 8;
    localparam int FLAG_RI      = 7;
    localparam int FLAG_OV      = 6;
    localparam int FLAG_TRAP    = 5;
    localparam int FLAG_SYSCALL = 4;
    localparam int FLAG_BREAK   = 3;
    localparam int FLAG_ERET    = 2;
    localparam int FLAG_ADEL_LD = 1;
    localparam int FLAG_ADES_ST = 0;

    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_ADEL    = 32'h4;
    localparam logic [31:0] EXC_ADES    = 32'h5;
    localparam logic [31:0] EXC_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_BREAK   = 32'h9;
    localparam logic [31:0] EXC_RI      = 32'ha;
    localparam logic [31:0] EXC_OV      = 32'hc;
    localparam logic [31:0] EXC_TRAP    = 32'hd;
    localparam logic [31:0] EXC_ERET    = 32'he;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;

    typedef enum logic [1:0] {
        ADDR_KEEP = 2'd0,
        ADDR_PC   = 2'd1,
        ADDR_MEM  = 2'd2
    } addr_sel_t;

endpackage

// File: rtl/except_ctrl_exc_prio_enc.sv
// Fixed-priority exception selector: picks one code from the pending flags and
// tells the caller where the bad virtual address (if any) comes from.
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic [FLAG_W-1:0] flags_i,
    input  logic              int_pending_i,
    output logic [31:0]       code_o,
    output addr_sel_t         addr_sel_o
);

    always_comb begin
        code_o     = EXC_NONE;
        addr_sel_o = ADDR_KEEP;
        if (int_pending_i) begin
            code_o = EXC_INT;
        end else if (flags_i[FLAG_ADEL_IF]) begin
            code_o     = EXC_ADEL;
            addr_sel_o = ADDR_PC;
        end else if (flags_i[FLAG_RI]) begin
            code_o = EXC_RI;
        end else if (flags_i[FLAG_OV]) begin
            code_o = EXC_OV;
        end else if (flags_i[FLAG_TRAP]) begin
            code_o = EXC_TRAP;
        end else if (flags_i[FLAG_SYSCALL]) begin
            code_o = EXC_SYSCALL;
        end else if (flags_i[FLAG_BREAK]) begin
            code_o = EXC_BREAK;
        end else if (flags_i[FLAG_ERET]) begin
            code_o = EXC_ERET;
        end else if (flags_i[FLAG_ADEL_LD]) begin
            code_o     = EXC_ADEL;
            addr_sel_o = ADDR_MEM;
        end else if (flags_i[FLAG_ADES_ST]) begin
            code_o     = EXC_ADES;
            addr_sel_o = ADDR_MEM;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: reports one exception per flush to CP0 and
// then ignores the MEM stage for HOLD_CYCLES cycles while the pipeline drains.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic              stall_i,
    input  logic [31:0]       pc_i,
    input  logic              is_in_delayslot_i,
    input  logic [FLAG_W-1:0] exc_flags_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       status_i,
    input  logic [31:0]       cause_i,
    input  logic [31:0]       epc_i,
    output logic [31:0]       excepttype_o,
    output logic [31:0]       current_inst_addr_o,
    output logic [31:0]       bad_addr_o,
    output logic              is_in_delayslot_o,
    output logic              flush_o,
    output logic [31:0]       new_pc_o,
    output logic              dbg_state_o,
    output logic [1:0]        dbg_hold_cnt_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [1:0] HOLD_INIT = 2'(HOLD_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] bad_addr_q, bad_addr_d;

    logic        int_pending;
    logic        take;
    logic        exc_taken;
    logic [31:0] enc_code;
    addr_sel_t   enc_sel;
    logic [31:0] code;

    // Interrupts need IE set, EXL clear and at least one unmasked pending line.
    assign int_pending = status_i[STATUS_IE] && !status_i[STATUS_EXL]
                         && ((cause_i[CAUSE_IP_HI:CAUSE_IP_LO]
                              & status_i[STATUS_IM_HI:STATUS_IM_LO]) != 8'h00);

    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    exc_prio_enc u_prio (
        .flags_i       (exc_flags_i),
        .int_pending_i (int_pending),
        .code_o        (enc_code),
        .addr_sel_o    (enc_sel)
    );

    assign take      = (state_q == ST_RUN) && mem_valid_i && !stall_i;
    assign code      = take ? enc_code : EXC_NONE;
    assign exc_taken = (code != EXC_NONE);

    always_comb begin
        bad_addr_d = bad_addr_q;
        if (take) begin
            case (enc_sel)
                ADDR_PC:  bad_addr_d = pc_i;
                ADDR_MEM: bad_addr_d = mem_addr_i;
                default:  bad_addr_d = bad_addr_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (exc_taken) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                // Counts down regardless of stall so the drain window is fixed in time.
                if (cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 2'd0;
            bad_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign excepttype_o        = rst ? code : EXC_NONE;
    assign flush_o             = rst && exc_taken;
    assign current_inst_addr_o = (rst && exc_taken) ? pc_i : 32'h0;
    assign is_in_delayslot_o   = rst && exc_taken && is_in_delayslot_i;
    assign new_pc_o            = !(rst && exc_taken) ? 32'h0 :
                                 (code == EXC_ERET) ? epc_i : EXC_VECTOR;
    assign bad_addr_o          = rst ? bad_addr_d : 32'h0;
    assign dbg_state_o         = state_q[0];
    assign dbg_hold_cnt_o      = cnt_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: hand-computed vectors for priority, hold
// window, stall handling, bad-address capture and reset behaviour.
module tb_except_ctrl;

    localparam logic [8:0] F_NONE    = 9'h000;
    localparam logic [8:0] F_ADEL_IF = 9'h100;
    localparam logic [8:0] F_RI      = 9'h080;
    localparam logic [8:0] F_OV      = 9'h040;
    localparam logic [8:0] F_TRAP    = 9'h020;
    localparam logic [8:0] F_SYS     = 9'h010;
    localparam logic [8:0] F_BRK     = 9'h008;
    localparam logic [8:0] F_ERET    = 9'h004;
    localparam logic [8:0] F_LD      = 9'h002;
    localparam logic [8:0] F_ST      = 9'h001;
    localparam logic [31:0] VEC      = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic [31:0] bad_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        dbg_state_o;
    logic [1:0]  dbg_hold_cnt_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    except_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .stall_i             (stall_i),
        .pc_i                (pc_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .exc_flags_i         (exc_flags_i),
        .mem_addr_i          (mem_addr_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .bad_addr_o          (bad_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .dbg_state_o         (dbg_state_o),
        .dbg_hold_cnt_o      (dbg_hold_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] pc, input logic ds,
                         input logic [8:0] fl, input logic [31:0] addr);
        mem_valid_i       = v;
        stall_i           = s;
        pc_i              = pc;
        is_in_delayslot_i = ds;
        exc_flags_i       = fl;
        mem_addr_i        = addr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_exc(input string tag, input logic [31:0] code, input logic [31:0] npc,
                              input logic [31:0] cur, input logic ds, input logic [31:0] bad);
        check({tag, ".code"}, excepttype_o, code);
        check({tag, ".flush"}, {31'h0, flush_o}, 32'h1);
        check({tag, ".new_pc"}, new_pc_o, npc);
        check({tag, ".cur_pc"}, current_inst_addr_o, cur);
        check({tag, ".ds"}, {31'h0, is_in_delayslot_o}, {31'h0, ds});
        check({tag, ".bad"}, bad_addr_o, bad);
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, ".code"}, excepttype_o, 32'h0);
        check({tag, ".flush"}, {31'h0, flush_o}, 32'h0);
        check({tag, ".new_pc"}, new_pc_o, 32'h0);
        check({tag, ".cur_pc"}, current_inst_addr_o, 32'h0);
    endtask

    task automatic hold_idle(input string tag, input int n);
        drive(1'b0, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0);
        for (int i = 0; i < n; i++) begin
            sample();
            check({tag, ".hold_state"}, {31'h0, dbg_state_o}, 32'h1);
            check({tag, ".hold_flush"}, {31'h0, flush_o}, 32'h0);
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        status_i = 32'h0;
        cause_i  = 32'h0;
        epc_i    = 32'h0;
        drive(1'b1, 1'b0, 32'h8000_0010, 1'b1, F_SYS, 32'h1234);
        #3;
        expect_quiet("reset");
        check("reset.bad", bad_addr_o, 32'h0);
        check("reset.ds", {31'h0, is_in_delayslot_o}, 32'h0);
        check("reset.state", {31'h0, dbg_state_o}, 32'h0);
        check("reset.cnt", {30'h0, dbg_hold_cnt_o}, 32'h0);
        repeat (2) @(posedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Interrupt: IE=1, EXL=0, IM2 & IP2 set
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        drive(1'b1, 1'b0, 32'h8000_0100, 1'b0, F_NONE, 32'h0);
        sample();
        expect_exc("irq", 32'h1, VEC, 32'h8000_0100, 1'b0, 32'h0);
        next_cycle();
        status_i = 32'h0;
        cause_i  = 32'h0;
        hold_idle("irq", 3);

        // adel_ld in a delay slot captures mem_addr
        drive(1'b1, 1'b0, 32'h8000_0040, 1'b1, F_LD, 32'h8000_0003);
        sample();
        expect_exc("adel_ld", 32'h4, VEC, 32'h8000_0040, 1'b1, 32'h8000_0003);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, F_NONE, 32'h0);
        sample();
        check("adel_ld.bad_held", bad_addr_o, 32'h8000_0003);
        check("adel_ld.cnt", {30'h0, dbg_hold_cnt_o}, 32'h2);
        next_cycle();
        hold_idle("adel_ld", 2);

        // adel_if beats ades_st and captures pc
        drive(1'b1, 1'b0, 32'h8000_0005, 1'b0, F_ADEL_IF | F_ST, 32'h9000_0000);
        sample();
        expect_exc("adel_if", 32'h4, VEC, 32'h8000_0005, 1'b0, 32'h8000_0005);
        next_cycle();
        hold_idle("adel_if", 3);

        // eret, then syscall right behind it is held off for the whole window
        epc_i = 32'h8000_0200;
        drive(1'b1, 1'b0, 32'h8000_0300, 1'b0, F_ERET, 32'h0);
        sample();
        expect_exc("eret", 32'he, 32'h8000_0200, 32'h8000_0300, 1'b0, 32'h8000_0005);
        next_cycle();
        drive(1'b1, 1'b0, 32'h8000_0304, 1'b0, F_SYS, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            expect_quiet("sys_in_hold");
            check("sys_in_hold.state", {31'h0, dbg_state_o}, 32'h1);
            next_cycle();
        end
        sample();
        expect_exc("sys_after_hold", 32'h8, VEC, 32'h8000_0304, 1'b0, 32'h8000_0005);
        next_cycle();
        hold_idle("sys_after_hold", 3);

        // Valid instruction without flags: nothing reported, bad_addr kept
        drive(1'b1, 1'b0, 32'h8000_0400, 1'b1, F_NONE, 32'h7777_0000);
        sample();
        expect_quiet("no_exc");
        check("no_exc.ds", {31'h0, is_in_delayslot_o}, 32'h0);
        check("no_exc.bad", bad_addr_o, 32'h8000_0005);
        next_cycle();
        check("no_exc.state", {31'h0, dbg_state_o}, 32'h0);

        // Stalled syscall waits, then fires on the first unstalled cycle
        drive(1'b1, 1'b1, 32'h8000_0500, 1'b0, F_SYS, 32'h0);
        for (int i = 0; i < 2; i++) begin
            sample();
            expect_quiet("sys_stalled");
            check("sys_stalled.state", {31'h0, dbg_state_o}, 32'h0);
            next_cycle();
        end
        stall_i = 1'b0;
        sample();
        expect_exc("sys_unstalled", 32'h8, VEC, 32'h8000_0500, 1'b0, 32'h8000_0005);
        next_cycle();
        hold_idle("sys_unstalled", 3);

        // Interrupt with ov reports only the interrupt; reset during HOLD
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        drive(1'b1, 1'b0, 32'h8000_0600, 1'b0, F_OV, 32'h0);
        sample();
        expect_exc("irq_ov", 32'h1, VEC, 32'h8000_0600, 1'b0, 32'h8000_0005);
        next_cycle();
        status_i = 32'h0;
        cause_i  = 32'h0;
        sample();
        expect_quiet("irq_ov_hold");
        check("irq_ov_hold.state", {31'h0, dbg_state_o}, 32'h1);
        rst = 1'b0;
        #1;
        expect_quiet("rst_in_hold");
        check("rst_in_hold.state", {31'h0, dbg_state_o}, 32'h0);
        check("rst_in_hold.cnt", {30'h0, dbg_hold_cnt_o}, 32'h0);
        check("rst_in_hold.bad", bad_addr_o, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        expect_exc("ov_after_rst", 32'hc, VEC, 32'h8000_0600, 1'b0, 32'h0);
        next_cycle();
        hold_idle("ov_after_rst", 3);

        // Priority corners
        drive(1'b1, 1'b0, 32'h8000_0700, 1'b0, F_ERET | F_RI, 32'h0);
        sample();
        expect_exc("eret_ri", 32'ha, VEC, 32'h8000_0700, 1'b0, 32'h0);
        next_cycle();
        hold_idle("eret_ri", 3);

        drive(1'b1, 1'b0, 32'h8000_0710, 1'b1, F_TRAP | F_SYS | F_BRK, 32'h0);
        sample();
        expect_exc("trap_sys", 32'hd, VEC, 32'h8000_0710, 1'b1, 32'h0);
        next_cycle();
        hold_idle("trap_sys", 3);

        // EXL set masks the interrupt, so break wins
        status_i = 32'h0000_0403;
        cause_i  = 32'h0000_0400;
        drive(1'b1, 1'b0, 32'h8000_0720, 1'b0, F_BRK | F_ERET, 32'h0);
        sample();
        expect_exc("exl_brk", 32'h9, VEC, 32'h8000_0720, 1'b0, 32'h0);
        next_cycle();
        status_i = 32'h0;
        cause_i  = 32'h0;
        hold_idle("exl_brk", 3);

        drive(1'b1, 1'b0, 32'h8000_0730, 1'b0, F_ST, 32'h8000_0011);
        sample();
        expect_exc("ades_st", 32'h5, VEC, 32'h8000_0730, 1'b0, 32'h8000_0011);
        next_cycle();
        hold_idle("ades_st", 3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, exception entry PC.
REQ-002 Parameter HOLD_CYCLES, default 3, post-flush cycles during which the MEM stage is ignored.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mem_valid_i  input  1  MEM stage holds a real instruction.
REQ-006 stall_i  input  1  MEM stage stalled this cycle.
REQ-007 pc_i  input  32  MEM-stage instruction address.
REQ-008 is_in_delayslot_i  input  1  MEM instruction is in a delay slot.
REQ-009 exc_flags_i  input  9  {adel_if, ri, ov, trap, syscall, break, eret, adel_ld, ades_st}, bit 8 = adel_if.
REQ-010 mem_addr_i  input  32  load/store effective address.
REQ-011 status_i, cause_i, epc_i  input  32 each  forwarded CP0 Status/Cause/EPC values.
REQ-012 excepttype_o  output  32  exception code to CP0, 0 = none.
REQ-013 current_inst_addr_o, bad_addr_o  output  32 each  faulting PC / bad virtual address to CP0.
REQ-014 is_in_delayslot_o  output  1  delay-slot flag to CP0.
REQ-015 flush_o  output  1  pipeline flush pulse.
REQ-016 new_pc_o  output  32  redirect target, valid while flush_o=1.

Function
REQ-017 The block SHALL implement FSM states RUN and HOLD plus a 2-bit hold counter.
REQ-018 In RUN with mem_valid_i=1 and stall_i=0, the block SHALL select one code by fixed priority: interrupt 0x1 > adel_if 0x4 > ri 0xa > ov 0xc > trap 0xd > syscall 0x8 > break 0x9 > eret 0xe > adel_ld 0x4 > ades_st 0x5.
REQ-019 Interrupt pending SHALL be status_i[0]=1 AND status_i[1]=0 AND (cause_i[15:8] & status_i[15:8]) != 0.
REQ-020 excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o and new_pc_o SHALL be combinational in the selecting cycle (zero latency, ahead of the CP0 negedge write).
REQ-021 current_inst_addr_o SHALL equal pc_i and is_in_delayslot_o SHALL equal is_in_delayslot_i whenever excepttype_o != 0; otherwise both are 0.
REQ-022 bad_addr_o SHALL be pc_i for adel_if, mem_addr_i for adel_ld/ades_st, and otherwise hold its last registered value.
REQ-023 new_pc_o SHALL be epc_i for code 0xe and EXC_VECTOR for all other codes.
REQ-024 When a code is selected, the next state SHALL be HOLD with counter = HOLD_CYCLES-1.
REQ-025 In HOLD, excepttype_o and flush_o SHALL be 0 regardless of inputs; the counter decrements every cycle, stall_i included; at 0 the next state is RUN.
REQ-026 With stall_i=1 or mem_valid_i=0 in RUN, outputs SHALL be 0 and the state SHALL be unchanged; a pending flag SHALL be reconsidered on the first unstalled valid cycle.
REQ-027 An interrupt coinciding with a synchronous flag SHALL report 0x1 only.
REQ-028 An eret coinciding with ri or ov SHALL report the higher-priority code.
REQ-029 Two back-to-back exceptions SHALL produce one flush; the second is suppressed by HOLD.

Reset
REQ-030 While rst=0: state=RUN, counter=0, bad_addr register=0, and all outputs=0, asynchronously.
REQ-031 Reset asserted during HOLD SHALL return the FSM to RUN with no flush pulse.

Structure
REQ-032 Exception codes (0x1, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc, 0xd, 0xe), flag bit indices and Status/Cause field positions SHALL live in the shared defines header.
REQ-033 The priority selector SHALL be a combinational sub-module exc_prio_enc (flags + int_pending -> code + addr-source select).

Verification
REQ-034 Status=0x0000_0401, Cause=0x0000_0400, valid, pc=0x8000_0100 -> excepttype_o=1, flush_o=1, new_pc_o=0xBFC00380, current_inst_addr_o=0x8000_0100.
REQ-035 adel_ld with mem_addr_i=0x8000_0003, delay slot=1 -> code 4, bad_addr_o=0x8000_0003, is_in_delayslot_o=1.
REQ-036 eret with epc_i=0x8000_0200 -> code 0xe, new_pc_o=0x8000_0200; syscall on the next cycle -> suppressed (HOLD) for 3 cycles, then reported.
REQ-037 syscall with stall_i=1 for 2 cycles -> no output; stall_i=0 -> code 8 in that cycle.
REQ-038 Interrupt plus ov in the same cycle -> code 1 only; rst pulse during HOLD -> RUN immediately, all outputs 0.
